// File: rtl/jts16_snd_cmdfifo.sv
// jts16_snd_cmdfifo
//   Main-CPU -> sound-CPU command FIFO (first-word-fall-through) with an
//   optional one-byte reply latch going back to the main CPU.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous clear of FIFO pointers/level, ovf and IRQ pulse
//   main_wr/main_din    command push strobe (edge-acting) and data
//   main_rd             reply read strobe (edge-acting), clears main_rdy
//   main_dout/main_rdy  reply byte and reply-pending flag
//   main_full           FIFO full
//   snd_rd              pop strobe (edge-acting); snd_dout shows the head entry
//   snd_wr/snd_din      reply write strobe (edge-acting) and data
//   snd_empty, pbf      FIFO empty / not empty
//   int_n               active-low interrupt to the sound CPU (IRQ_MODE selects style)
//   level               number of entries held, 0..DEPTH
//   ovf                 sticky: a push was dropped because the FIFO was full
module jts16_snd_cmdfifo #(
    parameter int unsigned DW       = 8,
    parameter int unsigned AW       = 2,
    parameter int unsigned IRQ_MODE = 0,
    parameter int unsigned IRQW     = 64,
    parameter int unsigned REPLY    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          main_wr,
    input  logic [DW-1:0] main_din,
    input  logic          main_rd,
    output logic [DW-1:0] main_dout,
    output logic          main_rdy,
    output logic          main_full,
    input  logic          snd_rd,
    output logic [DW-1:0] snd_dout,
    input  logic          snd_wr,
    input  logic [DW-1:0] snd_din,
    output logic          snd_empty,
    output logic          pbf,
    output logic          int_n,
    output logic [AW:0]   level,
    output logic          ovf
);

    localparam int unsigned DEPTH = 2**AW;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned CW    = $clog2(IRQW + 1);

    typedef enum logic {IRQ_IDLE, IRQ_PULSE} irq_state_t;

    // Strobe history for edge detection
    logic          main_wr_q, main_rd_q, snd_rd_q, snd_wr_q;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [DW-1:0] snd_dout_q, snd_dout_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          pbf_q, pbf_d;
    logic          int_n_q, int_n_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] main_dout_q, main_dout_d;
    logic          main_rdy_q, main_rdy_d;
    logic [CW-1:0] cnt_q, cnt_d;
    irq_state_t    state_q, state_d;

    logic          wr_edge_c, rd_edge_c, pop_edge_c, rep_edge_c;
    logic          do_push_c, do_pop_c;

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_wr_q   <= 1'b0;
            main_rd_q   <= 1'b0;
            snd_rd_q    <= 1'b0;
            snd_wr_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            snd_dout_q  <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            pbf_q       <= 1'b0;
            int_n_q     <= 1'b1;
            ovf_q       <= 1'b0;
            main_dout_q <= '0;
            main_rdy_q  <= 1'b0;
            cnt_q       <= '0;
            state_q     <= IRQ_IDLE;
        end else begin
            main_wr_q   <= main_wr;
            main_rd_q   <= main_rd;
            snd_rd_q    <= snd_rd;
            snd_wr_q    <= snd_wr;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            snd_dout_q  <= snd_dout_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            pbf_q       <= pbf_d;
            int_n_q     <= int_n_d;
            ovf_q       <= ovf_d;
            main_dout_q <= main_dout_d;
            main_rdy_q  <= main_rdy_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
        end
    end

    // Next-state: FIFO, flags, IRQ FSM and reply latch
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ovf_d       = ovf_q;
        int_n_d     = int_n_q;
        cnt_d       = cnt_q;
        state_d     = state_q;
        main_dout_d = main_dout_q;
        main_rdy_d  = main_rdy_q;

        wr_edge_c   = main_wr & ~main_wr_q;
        rd_edge_c   = main_rd & ~main_rd_q;
        pop_edge_c  = snd_rd  & ~snd_rd_q;
        rep_edge_c  = snd_wr  & ~snd_wr_q;

        // A pop in the same cycle frees the slot a push into a full FIFO needs
        do_pop_c    = pop_edge_c & (level_q != '0) & ~flush;
        do_push_c   = wr_edge_c & ((level_q != LW'(DEPTH)) | do_pop_c) & ~flush;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push_c) begin
                mem_d[wr_ptr_q] = main_din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push_c && !do_pop_c) begin
                level_d = level_q + LW'(1);
            end else if (!do_push_c && do_pop_c) begin
                level_d = level_q - LW'(1);
            end
            if (wr_edge_c && !do_push_c) begin
                ovf_d = 1'b1;
            end
        end

        // Empty FIFO keeps showing the last head rather than stale storage
        snd_dout_d = (level_d != '0) ? mem_d[rd_ptr_d] : snd_dout_q;
        full_d     = (level_d == LW'(DEPTH));
        empty_d    = (level_d == '0);
        pbf_d      = (level_d != '0);

        if (IRQ_MODE == 0) begin
            int_n_d = (level_d == '0);
        end else begin
            case (state_q)
                IRQ_IDLE: begin
                    if (do_push_c) begin
                        state_d = IRQ_PULSE;
                        cnt_d   = CW'(IRQW);
                        int_n_d = 1'b0;
                    end
                end
                IRQ_PULSE: begin
                    if (do_push_c) begin
                        cnt_d   = CW'(IRQW);
                        int_n_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                        if (cnt_d == '0) begin
                            state_d = IRQ_IDLE;
                            int_n_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IRQ_IDLE;
                    int_n_d = 1'b1;
                end
            endcase
            if (flush) begin
                state_d = IRQ_IDLE;
                cnt_d   = '0;
                int_n_d = 1'b1;
            end
        end

        // Reply load wins over a simultaneous main-side read
        if (REPLY != 0) begin
            if (rep_edge_c) begin
                main_dout_d = snd_din;
                main_rdy_d  = 1'b1;
            end else if (rd_edge_c) begin
                main_rdy_d  = 1'b0;
            end
        end else begin
            main_dout_d = '0;
            main_rdy_d  = 1'b0;
        end
    end

    assign main_dout = main_dout_q;
    assign main_rdy  = main_rdy_q;
    assign main_full = full_q;
    assign snd_dout  = snd_dout_q;
    assign snd_empty = empty_q;
    assign pbf       = pbf_q;
    assign int_n     = int_n_q;
    assign level     = level_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_jts16_snd_cmdfifo.sv
// Bench for jts16_snd_cmdfifo: directed steps plus randomized operations
// checked against a queue-based reference model.
module tb_jts16_snd_cmdfifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    // Main instance (IRQ_MODE 0)
    logic       flush = 0, main_wr = 0, main_rd = 0, snd_rd = 0, snd_wr = 0;
    logic [7:0] main_din = 0, snd_din = 0;
    logic [7:0] main_dout, snd_dout;
    logic       main_rdy, main_full, snd_empty, pbf, int_n, ovf;
    logic [2:0] level;

    // Pulse-IRQ instance
    logic       i_wr = 0;
    logic [7:0] i_din = 0;
    logic [7:0] i_main_dout, i_snd_dout;
    logic       i_main_rdy, i_main_full, i_snd_empty, i_pbf, i_int_n, i_ovf;
    logic [2:0] i_level;

    int checks = 0;
    int errors = 0;

    // Reference model
    logic [7:0] mq[$];
    logic       m_ovf  = 0;
    logic [7:0] m_dout = 0;
    logic       m_rdy  = 0;
    logic [7:0] m_head = 0;

    always #5 clk = ~clk;

    jts16_snd_cmdfifo #(.DW(8), .AW(2), .IRQ_MODE(0), .IRQW(64), .REPLY(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .main_wr(main_wr), .main_din(main_din), .main_rd(main_rd),
        .main_dout(main_dout), .main_rdy(main_rdy), .main_full(main_full),
        .snd_rd(snd_rd), .snd_dout(snd_dout), .snd_wr(snd_wr), .snd_din(snd_din),
        .snd_empty(snd_empty), .pbf(pbf), .int_n(int_n), .level(level), .ovf(ovf)
    );

    jts16_snd_cmdfifo #(.DW(8), .AW(2), .IRQ_MODE(1), .IRQW(64), .REPLY(1)) u_dut_irq (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .main_wr(i_wr), .main_din(i_din), .main_rd(1'b0),
        .main_dout(i_main_dout), .main_rdy(i_main_rdy), .main_full(i_main_full),
        .snd_rd(1'b0), .snd_dout(i_snd_dout), .snd_wr(1'b0), .snd_din(8'h00),
        .snd_empty(i_snd_empty), .pbf(i_pbf), .int_n(i_int_n), .level(i_level), .ovf(i_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ":level"},     32'(level),     32'(n));
        chk({tag, ":empty"},     32'(snd_empty), 32'(n == 0));
        chk({tag, ":pbf"},       32'(pbf),       32'(n != 0));
        chk({tag, ":full"},      32'(main_full), 32'(n == DEPTH));
        chk({tag, ":int_n"},     32'(int_n),     32'(n == 0));
        chk({tag, ":ovf"},       32'(ovf),       32'(m_ovf));
        chk({tag, ":snd_dout"},  32'(snd_dout),  32'(m_head));
        chk({tag, ":main_dout"}, 32'(main_dout), 32'(m_dout));
        chk({tag, ":main_rdy"},  32'(main_rdy),  32'(m_rdy));
    endtask

    // One operation: strobes high for one cycle, then low for one cycle
    task automatic do_op(input bit push, input bit pop, input bit fl, input bit swr,
                         input bit mrd, input logic [7:0] din, input logic [7:0] sdin,
                         input string tag);
        bit popped;
        if (fl) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            popped = pop && (mq.size() > 0);
            if (popped) void'(mq.pop_front());
            if (push) begin
                if (mq.size() < DEPTH) mq.push_back(din);
                else m_ovf = 1;
            end
        end
        if (mq.size() > 0) m_head = mq[0];
        if (swr) begin
            m_dout = sdin;
            m_rdy  = 1;
        end else if (mrd) begin
            m_rdy = 0;
        end

        main_wr = push; snd_rd = pop; flush = fl; snd_wr = swr; main_rd = mrd;
        main_din = din; snd_din = sdin;
        step();
        main_wr = 0; snd_rd = 0; flush = 0; snd_wr = 0; main_rd = 0;
        step();
        check_all(tag);
    endtask

    initial begin
        logic [7:0] exp_seq [4];

        // Reset
        step(); step();
        chk("rst:empty", 32'(snd_empty), 32'd1);
        chk("rst:pbf",   32'(pbf),       32'd0);
        chk("rst:int_n", 32'(int_n),     32'd1);
        chk("rst:level", 32'(level),     32'd0);
        chk("rst:rdy",   32'(main_rdy),  32'd0);
        chk("rst:ovf",   32'(ovf),       32'd0);
        chk("rst:irq_int_n", 32'(i_int_n), 32'd1);
        rst_n = 1'b1;
        step();
        check_all("idle");

        // Fill, overflow, drain
        do_op(1, 0, 0, 0, 0, 8'h11, 8'h00, "push11");
        do_op(1, 0, 0, 0, 0, 8'h22, 8'h00, "push22");
        do_op(1, 0, 0, 0, 0, 8'h33, 8'h00, "push33");
        do_op(1, 0, 0, 0, 0, 8'h44, 8'h00, "push44");
        chk("fill:full",  32'(main_full), 32'd1);
        chk("fill:level", 32'(level),     32'd4);
        do_op(1, 0, 0, 0, 0, 8'h55, 8'h00, "push55");
        chk("ovf:ovf",   32'(ovf),   32'd1);
        chk("ovf:level", 32'(level), 32'd4);
        exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            chk("drain:head", 32'(snd_dout), 32'(exp_seq[i]));
            do_op(0, 1, 0, 0, 0, 8'h00, 8'h00, "drain");
        end
        chk("drain:empty", 32'(snd_empty), 32'd1);
        do_op(0, 1, 0, 0, 0, 8'h00, 8'h00, "pop_empty");
        chk("pop_empty:hold", 32'(snd_dout), 32'h44);

        // Held strobes act once
        main_din = 8'hA5; main_wr = 1;
        for (int i = 0; i < 10; i++) step();
        main_wr = 0; step();
        mq.push_back(8'hA5); m_head = 8'hA5;
        chk("hold_wr:level", 32'(level), 32'd1);
        check_all("hold_wr");
        snd_rd = 1;
        for (int i = 0; i < 10; i++) step();
        snd_rd = 0; step();
        void'(mq.pop_front());
        chk("hold_rd:level", 32'(level), 32'd0);
        check_all("hold_rd");

        // Push+pop on a full FIFO with wrap-around
        do_op(0, 0, 1, 0, 0, 8'h00, 8'h00, "flush_ovf");
        do_op(1, 0, 0, 0, 0, 8'h11, 8'h00, "f11");
        do_op(1, 0, 0, 0, 0, 8'h22, 8'h00, "f22");
        do_op(1, 0, 0, 0, 0, 8'h33, 8'h00, "f33");
        do_op(1, 0, 0, 0, 0, 8'h44, 8'h00, "f44");
        chk("pp:head", 32'(snd_dout), 32'h11);
        do_op(1, 1, 0, 0, 0, 8'h66, 8'h00, "pushpop_full");
        chk("pp:level", 32'(level), 32'd4);
        chk("pp:ovf",   32'(ovf),   32'd0);
        exp_seq = '{8'h22, 8'h33, 8'h44, 8'h66};
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain:head", 32'(snd_dout), 32'(exp_seq[i]));
            do_op(0, 1, 0, 0, 0, 8'h00, 8'h00, "pp_drain");
        end
        // Push+pop on empty: push only
        do_op(1, 1, 0, 0, 0, 8'h77, 8'h00, "pushpop_empty");
        chk("ppe:level", 32'(level), 32'd1);
        chk("ppe:head",  32'(snd_dout), 32'h77);

        // Reply latch and flush
        do_op(0, 0, 0, 1, 0, 8'h00, 8'h3C, "reply");
        chk("reply:dout", 32'(main_dout), 32'h3C);
        chk("reply:rdy",  32'(main_rdy),  32'd1);
        do_op(0, 0, 0, 0, 1, 8'h00, 8'h00, "reply_rd");
        chk("reply_rd:rdy",  32'(main_rdy),  32'd0);
        chk("reply_rd:dout", 32'(main_dout), 32'h3C);
        do_op(0, 0, 0, 1, 1, 8'h00, 8'h5A, "reply_both");
        chk("reply_both:rdy", 32'(main_rdy), 32'd1);
        do_op(1, 0, 0, 0, 0, 8'h01, 8'h00, "pre_flush1");
        do_op(1, 0, 0, 0, 0, 8'h02, 8'h00, "pre_flush2");
        chk("pre_flush:level", 32'(level), 32'd3);
        do_op(1, 1, 1, 0, 0, 8'h03, 8'h00, "flush");
        chk("flush:level", 32'(level),    32'd0);
        chk("flush:rdy",   32'(main_rdy), 32'd1);

        // Pulse IRQ: push at t0, second push at t0+30
        for (int i = 0; i < 100; i++) begin
            i_wr = (i == 0 || i == 30);
            i_din = 8'(i);
            step();
            chk("irq2:int_n", 32'(i_int_n), 32'(i >= 94));
        end
        // Single push after the FIFO has room: 64-cycle pulse; then a dropped push
        for (int i = 0; i < 70; i++) begin
            i_wr = (i == 0);
            step();
            chk("irq1:int_n", 32'(i_int_n), 32'(i >= 64));
        end
        i_wr = 1; step(); i_wr = 0; step();
        chk("irq_full:level", 32'(i_level), 32'd4);
        for (int i = 0; i < 70; i++) step();
        chk("irq_full:int_n_idle", 32'(i_int_n), 32'd1);
        i_wr = 1; step(); i_wr = 0;
        chk("irq_drop:ovf",   32'(i_ovf),   32'd1);
        chk("irq_drop:int_n", 32'(i_int_n), 32'd1);

        // Randomized operations
        for (int n = 0; n < 300; n++) begin
            do_op(1'($urandom % 2), 1'($urandom % 2), ($urandom % 16) == 0,
                  ($urandom % 4) == 0, ($urandom % 4) == 0,
                  8'($urandom), 8'($urandom), "rand");
        end

        // Asynchronous reset mid-operation
        do_op(0, 0, 0, 1, 0, 8'h00, 8'hEE, "pre_rst_reply");
        do_op(1, 0, 0, 0, 0, 8'h99, 8'h00, "pre_rst_push");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst:level", 32'(level),     32'd0);
        chk("arst:empty", 32'(snd_empty), 32'd1);
        chk("arst:pbf",   32'(pbf),       32'd0);
        chk("arst:dout",  32'(snd_dout),  32'd0);
        chk("arst:rdy",   32'(main_rdy),  32'd0);
        chk("arst:mdout", 32'(main_dout), 32'd0);
        chk("arst:ovf",   32'(ovf),       32'd0);
        chk("arst:int_n", 32'(int_n),     32'd1);
        chk("arst:irq_level", 32'(i_level), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
